// File: rtl/mips_pipe_controller.sv
// mips_pipe_controller: decodes the instruction in Decode and carries its
// control bits through the ID/EX, EX/MEM and MEM/WB control registers.
module mips_pipe_controller #(
   parameter int unsigned              ALUC_W      = 3,
   parameter logic [ALUC_W-1:0]        BUBBLE_ALUC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        OpD,
   input  logic [5:0]        FunctD,
   input  logic              EqualD,
   input  logic              FlushE,
   output logic              PCSrcD,
   output logic              JumpD,
   output logic              BranchD,
   output logic              IllegalD,
   output logic              RegWriteE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic [ALUC_W-1:0] ALUControlE,
   output logic              ALUSrcE,
   output logic              RegDstE,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              MemWriteM,
   output logic              RegWriteW,
   output logic              MemtoRegW,
   output logic              IllegalW
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
   localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
   localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
   localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
   localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);

   logic              regWriteDec, regDstDec, aluSrcDec, branchDec;
   logic              memWriteDec, memtoRegDec, jumpDec, opIllegal;
   logic [1:0]        aluOpDec;
   logic              functIllegal;
   logic [ALUC_W-1:0] aluControlDec;
   logic              illegalE, illegalM;

   // Main decoder: opcode to raw control bits; unused (x) fields stay 0.
   always_comb begin
      regWriteDec = 1'b0;
      regDstDec   = 1'b0;
      aluSrcDec   = 1'b0;
      branchDec   = 1'b0;
      memWriteDec = 1'b0;
      memtoRegDec = 1'b0;
      jumpDec     = 1'b0;
      aluOpDec    = 2'b00;
      opIllegal   = 1'b0;
      case (OpD)
         OP_RTYPE: begin
            regWriteDec = 1'b1;
            regDstDec   = 1'b1;
            aluOpDec    = 2'b10;
         end
         OP_LW: begin
            regWriteDec = 1'b1;
            aluSrcDec   = 1'b1;
            memtoRegDec = 1'b1;
         end
         OP_SW: begin
            aluSrcDec   = 1'b1;
            memWriteDec = 1'b1;
         end
         OP_BEQ: begin
            branchDec   = 1'b1;
            aluOpDec    = 2'b01;
         end
         OP_ADDI: begin
            regWriteDec = 1'b1;
            aluSrcDec   = 1'b1;
         end
         OP_J: begin
            jumpDec     = 1'b1;
         end
         default: opIllegal = 1'b1;
      endcase
   end

   // ALU decoder: ALUOp plus funct to the ALU control code.
   always_comb begin
      aluControlDec = BUBBLE_ALUC;
      functIllegal  = 1'b0;
      case (aluOpDec)
         2'b00: aluControlDec = ALU_ADD;
         2'b01: aluControlDec = ALU_SUB;
         default: begin
            case (FunctD)
               FN_ADD:  aluControlDec = ALU_ADD;
               FN_SUB:  aluControlDec = ALU_SUB;
               FN_AND:  aluControlDec = ALU_AND;
               FN_OR:   aluControlDec = ALU_OR;
               FN_SLT:  aluControlDec = ALU_SLT;
               default: functIllegal  = 1'b1;
            endcase
         end
      endcase
   end

   // Illegal instructions are neutralised before anything leaves Decode.
   assign IllegalD = opIllegal | functIllegal;
   assign BranchD  = branchDec & ~IllegalD;
   assign JumpD    = jumpDec & ~IllegalD;
   assign PCSrcD   = BranchD & EqualD;

   // ID/EX control register; FlushE loads a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteE   <= 1'b0;
         MemtoRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUControlE <= BUBBLE_ALUC;
         ALUSrcE     <= 1'b0;
         RegDstE     <= 1'b0;
         illegalE    <= 1'b0;
      end else if (FlushE) begin
         RegWriteE   <= 1'b0;
         MemtoRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUControlE <= BUBBLE_ALUC;
         ALUSrcE     <= 1'b0;
         RegDstE     <= 1'b0;
         illegalE    <= 1'b0;
      end else begin
         RegWriteE   <= regWriteDec & ~IllegalD;
         MemtoRegE   <= memtoRegDec;
         MemWriteE   <= memWriteDec & ~IllegalD;
         ALUControlE <= IllegalD ? BUBBLE_ALUC : aluControlDec;
         ALUSrcE     <= aluSrcDec;
         RegDstE     <= regDstDec;
         illegalE    <= IllegalD;
      end
   end

   // EX/MEM control register; advances every clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         MemWriteM <= 1'b0;
         illegalM  <= 1'b0;
      end else begin
         RegWriteM <= RegWriteE;
         MemtoRegM <= MemtoRegE;
         MemWriteM <= MemWriteE;
         illegalM  <= illegalE;
      end
   end

   // MEM/WB control register; advances every clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         IllegalW  <= 1'b0;
      end else begin
         RegWriteW <= RegWriteM;
         MemtoRegW <= MemtoRegM;
         IllegalW  <= illegalM;
      end
   end

endmodule

// File: tb/tb_mips_pipe_controller.sv
// Scoreboard bench for mips_pipe_controller: the driver pushes the expected
// Execute-stage controls per issued instruction, the monitor pops and checks
// E, then follows the same entry into M and W on later edges.
module tb_mips_pipe_controller;

   typedef struct packed {
      logic       regWrite;
      logic       memtoReg;
      logic       memWrite;
      logic [2:0] aluc;
      logic       aluSrc;
      logic       regDst;
      logic       illegal;
   } ctl_t;

   localparam ctl_t BUB   = '0;
   //                       rw    m2r   mw    aluc    src   dst   ill
   localparam ctl_t C_ADD  = '{1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0};
   localparam ctl_t C_SUB  = '{1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0};
   localparam ctl_t C_AND  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
   localparam ctl_t C_OR   = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0};
   localparam ctl_t C_SLT  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0};
   localparam ctl_t C_LW   = '{1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0};
   localparam ctl_t C_SW   = '{1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0};
   localparam ctl_t C_BEQ  = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0};
   localparam ctl_t C_ADDI = '{1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0};
   localparam ctl_t C_J    = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0};
   localparam ctl_t C_ILOP = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
   localparam ctl_t C_ILFN = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1};

   // expected Decode combinational outputs {PCSrcD, JumpD, BranchD, IllegalD}
   localparam logic [3:0] D_NONE = 4'b0000;
   localparam logic [3:0] D_BTK  = 4'b1010;
   localparam logic [3:0] D_BNT  = 4'b0010;
   localparam logic [3:0] D_JMP  = 4'b0100;
   localparam logic [3:0] D_ILL  = 4'b0001;

   logic       clk, rst_n;
   logic [5:0] OpD, FunctD;
   logic       EqualD, FlushE;
   logic       PCSrcD, JumpD, BranchD, IllegalD;
   logic       RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [2:0] ALUControlE;
   logic       RegWriteM, MemtoRegM, MemWriteM;
   logic       RegWriteW, MemtoRegW, IllegalW;

   int   checks = 0;
   int   errors = 0;
   ctl_t expQ[$];
   ctl_t monE, monM, monW;
   bit   monMValid = 1'b0;
   bit   monWValid = 1'b0;

   mips_pipe_controller dut (
      .clk(clk), .rst_n(rst_n), .OpD(OpD), .FunctD(FunctD), .EqualD(EqualD),
      .FlushE(FlushE), .PCSrcD(PCSrcD), .JumpD(JumpD), .BranchD(BranchD),
      .IllegalD(IllegalD), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .RegDstE(RegDstE), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
      .IllegalW(IllegalW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   task automatic checkAllZero(input string name);
      chk(name, 16'({RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
                     RegWriteM, MemtoRegM, MemWriteM, RegWriteW, MemtoRegW, IllegalW}), 16'h0);
   endtask

   // Drive one instruction into Decode on the falling edge and queue its E result.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                        input logic fl, input ctl_t exp, input logic [3:0] expD);
      @(negedge clk);
      OpD    = op;
      FunctD = fn;
      EqualD = eq;
      FlushE = fl;
      expQ.push_back(fl ? BUB : exp);
      #1;
      chk("decode_comb", 16'({PCSrcD, JumpD, BranchD, IllegalD}), 16'(expD));
   endtask

   task automatic bubble();
      issue(6'b000000, 6'b100000, 1'b0, 1'b1, C_ADD, D_NONE);
   endtask

   // Monitor: after each rising edge compare E against the queue head,
   // M and W against the entries popped one and two edges earlier.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            checkAllZero("reset_hold");
            expQ.delete();
            monM = BUB; monMValid = 1'b1;
            monW = BUB; monWValid = 1'b1;
         end else if (expQ.size() == 0) begin
            chk("scoreboard_underflow", 16'd1, 16'd0);
         end else begin
            monE = expQ.pop_front();
            chk("stageE", 16'({RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE}),
                16'({monE.regWrite, monE.memtoReg, monE.memWrite, monE.aluc, monE.aluSrc, monE.regDst}));
            if (monMValid)
               chk("stageM", 16'({RegWriteM, MemtoRegM, MemWriteM}),
                   16'({monM.regWrite, monM.memtoReg, monM.memWrite}));
            if (monWValid)
               chk("stageW", 16'({RegWriteW, MemtoRegW, IllegalW}),
                   16'({monW.regWrite, monW.memtoReg, monW.illegal}));
            monW = monM; monWValid = monMValid;
            monM = monE; monMValid = 1'b1;
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      OpD    = 6'b100011;
      FunctD = 6'b000000;
      EqualD = 1'b0;
      FlushE = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // R-type ALU operations back to back
      issue(6'b000000, 6'h20, 1'b0, 1'b0, C_ADD, D_NONE);
      issue(6'b000000, 6'h22, 1'b0, 1'b0, C_SUB, D_NONE);
      issue(6'b000000, 6'h24, 1'b0, 1'b0, C_AND, D_NONE);
      issue(6'b000000, 6'h25, 1'b0, 1'b0, C_OR,  D_NONE);
      issue(6'b000000, 6'h2A, 1'b0, 1'b0, C_SLT, D_NONE);
      // memory ops
      issue(6'b100011, 6'h00, 1'b0, 1'b0, C_LW,  D_NONE);
      issue(6'b101011, 6'h00, 1'b0, 1'b0, C_SW,  D_NONE);
      // branches taken / not taken, addi, jump
      issue(6'b000100, 6'h00, 1'b1, 1'b0, C_BEQ, D_BTK);
      issue(6'b000100, 6'h00, 1'b0, 1'b0, C_BEQ, D_BNT);
      issue(6'b001000, 6'h00, 1'b0, 1'b0, C_ADDI, D_NONE);
      issue(6'b000010, 6'h00, 1'b0, 1'b0, C_J,   D_JMP);
      // flushed lw becomes a bubble
      issue(6'b100011, 6'h00, 1'b0, 1'b1, C_LW,  D_NONE);
      // illegal opcode travels to W; flushed copy does not
      issue(6'b111111, 6'h00, 1'b0, 1'b0, C_ILOP, D_ILL);
      repeat (3) bubble();
      issue(6'b111111, 6'h00, 1'b0, 1'b1, C_ILOP, D_ILL);
      // unknown funct on an R-type
      issue(6'b000000, 6'h00, 1'b0, 1'b0, C_ILFN, D_ILL);
      repeat (3) bubble();

      // asynchronous reset with loads and a store in flight
      issue(6'b100011, 6'h00, 1'b0, 1'b0, C_LW, D_NONE);
      issue(6'b101011, 6'h00, 1'b0, 1'b0, C_SW, D_NONE);
      issue(6'b100011, 6'h00, 1'b0, 1'b0, C_LW, D_NONE);
      issue(6'b100011, 6'h00, 1'b0, 1'b0, C_LW, D_NONE);
      #1 rst_n = 1'b0;
      #1 checkAllZero("async_reset_drop");
      OpD = 6'b000100; FunctD = 6'h00; EqualD = 1'b1; FlushE = 1'b1;
      #1 chk("decode_comb_in_reset", 16'({PCSrcD, JumpD, BranchD, IllegalD}), 16'(D_BTK));
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) bubble();
      issue(6'b000000, 6'h20, 1'b0, 1'b0, C_ADD, D_NONE);
      repeat (3) bubble();

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_pipe_controller.md
Name: mips_pipe_controller

Overview:
- Pipelined control unit for the 5-stage MIPS core; it generates the ALU's control code.
- Decodes OpD/FunctD in Decode and produces the combinational Decode-stage controls.
- Carries the remaining control signals through the ID/EX, EX/MEM and MEM/WB control registers.
- Drives ALUControlE, ALUSrcE and RegDstE into the Execute stage, plus the Memory- and Writeback-stage enables.

Parameters:
- ALUC_W, 3, width of the ALU control code; fixed at 3 to match the Execute ALU encoding.
- BUBBLE_ALUC, 3'b000, ALUControlE value loaded on flush or reset.

Ports:
- clk  in  1  core clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OpD  in  6  opcode field of the instruction in Decode.
- FunctD  in  6  funct field of the instruction in Decode.
- EqualD  in  1  register-compare result from Decode.
- FlushE  in  1  hazard unit request to load a bubble into ID/EX.
- PCSrcD  out  1  branch taken; equals BranchD & EqualD.
- JumpD  out  1  jump in Decode.
- BranchD  out  1  beq in Decode.
- IllegalD  out  1  unrecognised opcode or funct in Decode.
- RegWriteE, MemtoRegE  out  1 each  Execute-stage copies, used by the hazard unit.
- MemWriteE  out  1  Execute-stage copy.
- ALUControlE  out  3  ALU operation code.
- ALUSrcE  out  1  selects the immediate as ALU operand B.
- RegDstE  out  1  selects rd (1) or rt (0) as the destination.
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  Memory-stage controls.
- RegWriteW, MemtoRegW  out  1 each  Writeback-stage controls.
- IllegalW  out  1  illegal instruction has reached Writeback.

Behaviour:
- Decode (combinational), as (RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUOp):
  - R-type 000000: 1,1,0,0,0,0,0,10
  - lw 100011: 1,0,1,0,0,1,0,00
  - sw 101011: 0,x,1,0,1,x,0,00
  - beq 000100: 0,x,0,1,0,x,0,01
  - addi 001000: 1,0,1,0,0,0,0,00
  - j 000010: 0,x,x,0,0,x,1,xx
  - The x entries are driven 0.
- ALU decode:
  - ALUOp 00 -> 010 (add); ALUOp 01 -> 110 (sub).
  - ALUOp 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111 (slt).
- Any other opcode, or any other funct with R-type:
  - IllegalD=1.
  - All write enables (RegWrite, MemWrite), Branch and Jump forced 0.
  - ALUControl = BUBBLE_ALUC.
- ID/EX register (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst, Illegal):
  - Loads the decoded values every clock.
  - If FlushE=1 at the edge, loads the bubble instead: all 1-bit fields 0, ALUControlE=BUBBLE_ALUC.
  - Branch and Jump are not pipelined.
- EX/MEM and MEM/WB advance unconditionally every clock; there is no stall below Decode.
  - Stalled Decode re-presents the same OpD/FunctD; the controller needs no StallD input.
- Latency: the decode of the instruction in D at edge n appears on the E outputs after edge n, M after n+1, W after n+2.
- Reset: rst_n low clears every pipeline register immediately, with no clock needed.
  - All registered outputs go to 0 and ALUControlE to BUBBLE_ALUC.
  - Reset wins over FlushE.
  - Reset mid-stream discards all in-flight controls; no write enable may glitch high on release.
- PCSrcD, JumpD, BranchD and IllegalD are purely combinational and are unaffected by reset.
- Simultaneous FlushE with an illegal opcode gives a bubble; IllegalE stays 0.

Test Plan:
- rst_n asserted mid-cycle with lw in flight -> RegWriteE/M/W, MemWriteM and ALUControlE all drop to 0 before the next clk; after release all stay 0 until a new instruction reaches them.
- Sequence add, sub, and, or, slt (Op 000000, Funct 20/22/24/25/2A hex), one per cycle -> ALUControlE = 010, 110, 000, 001, 111 on consecutive cycles starting one clk later; RegDstE=1; RegWriteW=1 three clks after each decode.
- lw then sw -> cycle E: ALUSrcE=1, ALUControlE=010, MemtoRegE=1; next edge MemWriteM=1 for sw only; MemtoRegW=1 for lw two edges after its E cycle.
- beq with EqualD=1 -> PCSrcD=1 in the same cycle; with EqualD=0 -> PCSrcD=0. Next cycle: RegWriteE=0, ALUControlE=110.
- lw in D with FlushE=1 -> after the edge all E controls are 0 and ALUControlE=000; M and W carry the bubble on the following edges.
- OpD=111111 -> IllegalD=1, no write enables; IllegalW=1 three edges later; repeat with FlushE=1 -> IllegalW stays 0.
